// File: rtl/board_controller.sv
// Checkers move controller: validates one diagonal step or jump per transaction and applies it.
// Handshake at N, move_done/move_ok at N+3, move_ready low while a move is in flight.
module board_controller #(
  parameter logic START_PLAYER = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         move_valid,
  output logic         move_ready,
  input  logic [5:0]   from_sq,
  input  logic [5:0]   to_sq,
  input  logic         new_game,
  output logic         move_done,
  output logic         move_ok,
  output logic         turn,
  output logic [255:0] boardBuffer
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CHECK  = 3'd1;
  localparam logic [2:0] S_APPLY  = 3'd2;
  localparam logic [2:0] S_REJECT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  function automatic logic [255:0] init_layout();
    logic [255:0] layout;
    layout = '0;
    for (int s = 0; s < 64; s++) begin
      if ((((s / 8) + (s % 8)) % 2) == 1) begin
        if ((s / 8) <= 2) layout[4*s +: 4] = 4'b0011;
        else if ((s / 8) >= 5) layout[4*s +: 4] = 4'b0001;
      end
    end
    return layout;
  endfunction

  localparam logic [255:0] INIT_LAYOUT = init_layout();

  logic [2:0]        state_q, state_d;
  logic [5:0]        from_q, from_d;
  logic [5:0]        to_q, to_d;
  logic              ok_q, ok_d;
  logic              turn_q, turn_d;
  logic [255:0]      board_q, board_d;

  logic [2:0]        from_row, from_col, to_row, to_col;
  logic [2:0]        mid_row, mid_col;
  logic [5:0]        mid_sq;
  logic signed [3:0] drow, dcol;
  logic              src_occ, src_own, src_king, dst_occ, mid_occ, mid_own;
  logic              dir1_ok, dir2_ok, base_ok, simple_ok, jump_ok, legal, promote;

  assign from_row = from_q[5:3];
  assign from_col = from_q[2:0];
  assign to_row   = to_q[5:3];
  assign to_col   = to_q[2:0];

  // Legality works on row/col deltas so a column wrap can never look adjacent.
  always_comb begin
    drow = $signed({1'b0, to_row}) - $signed({1'b0, from_row});
    dcol = $signed({1'b0, to_col}) - $signed({1'b0, from_col});

    mid_row = drow[3] ? from_row - 3'd1 : from_row + 3'd1;
    mid_col = dcol[3] ? from_col - 3'd1 : from_col + 3'd1;
    mid_sq  = {mid_row, mid_col};

    src_occ  = board_q[{from_q, 2'b00}];
    src_own  = board_q[{from_q, 2'b01}];
    src_king = board_q[{from_q, 2'b10}];
    dst_occ  = board_q[{to_q, 2'b00}];
    mid_occ  = board_q[{mid_sq, 2'b00}];
    mid_own  = board_q[{mid_sq, 2'b01}];

    dir1_ok = src_king ? (drow == 4'sd1 || drow == -4'sd1)
                       : (src_own ? (drow == 4'sd1) : (drow == -4'sd1));
    dir2_ok = src_king ? (drow == 4'sd2 || drow == -4'sd2)
                       : (src_own ? (drow == 4'sd2) : (drow == -4'sd2));

    base_ok   = src_occ && (src_own == turn_q) && !dst_occ;
    simple_ok = base_ok && (dcol == 4'sd1 || dcol == -4'sd1) && dir1_ok;
    jump_ok   = base_ok && (dcol == 4'sd2 || dcol == -4'sd2) && dir2_ok &&
                mid_occ && (mid_own != turn_q);
    legal     = simple_ok || jump_ok;

    promote = src_own ? (to_row == 3'd7) : (to_row == 3'd0);
  end

  always_comb begin
    state_d = state_q;
    from_d  = from_q;
    to_d    = to_q;
    ok_d    = ok_q;
    turn_d  = turn_q;
    board_d = board_q;

    case (state_q)
      S_IDLE: begin
        if (new_game) begin
          board_d = INIT_LAYOUT;
          turn_d  = START_PLAYER;
        end else if (move_valid) begin
          from_d  = from_sq;
          to_d    = to_sq;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        ok_d    = legal;
        state_d = legal ? S_APPLY : S_REJECT;
      end
      S_APPLY: begin
        board_d[{from_q, 2'b00} +: 4] = 4'b0000;
        if (jump_ok) board_d[{mid_sq, 2'b00} +: 4] = 4'b0000;
        board_d[{to_q, 2'b00} +: 4] = {1'b0, src_king | promote, src_own, 1'b1};
        turn_d  = ~turn_q;
        state_d = S_DONE;
      end
      S_REJECT: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      from_q  <= '0;
      to_q    <= '0;
      ok_q    <= 1'b0;
      turn_q  <= START_PLAYER;
      board_q <= INIT_LAYOUT;
    end else begin
      state_q <= state_d;
      from_q  <= from_d;
      to_q    <= to_d;
      ok_q    <= ok_d;
      turn_q  <= turn_d;
      board_q <= board_d;
    end
  end

  assign move_ready  = reset && !new_game && (state_q == S_IDLE);
  assign move_done   = reset && (state_q == S_DONE);
  assign move_ok     = move_done && ok_q;
  assign turn        = turn_q;
  assign boardBuffer = board_q;

endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller: square-array game model checked every cycle,
// plus directed moves with hand-computed nibble/turn/ok expectations.
module tb_board_controller;

  localparam logic START = 1'b0;
  localparam logic [255:0] INIT_LIT = {32'h01010101, 32'h10101010, 32'h01010101, 32'h00000000,
                                       32'h00000000, 32'h30303030, 32'h03030303, 32'h30303030};

  logic         clk, reset, move_valid, new_game;
  logic [5:0]   from_sq, to_sq;
  logic         move_ready, move_done, move_ok, turn;
  logic [255:0] boardBuffer;

  int n_pass = 0;
  int n_total = 0;
  bit saw_done;

  // Game model: one entry per square, plus a transaction phase counter.
  bit m_occ[64], m_own[64], m_king[64];
  bit m_turn, m_ok, m_jump, m_started;
  int m_phase, m_f, m_t;

  board_controller #(.START_PLAYER(START)) dut (
    .clk(clk), .reset(reset), .move_valid(move_valid), .move_ready(move_ready),
    .from_sq(from_sq), .to_sq(to_sq), .new_game(new_game), .move_done(move_done),
    .move_ok(move_ok), .turn(turn), .boardBuffer(boardBuffer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    chk(name, 256'(act), 256'(exp));
  endtask

  function automatic logic [3:0] nib(input int s);
    return boardBuffer[4*s +: 4];
  endfunction

  function automatic void model_init();
    for (int s = 0; s < 64; s++) begin
      m_occ[s]  = (((s / 8) + (s % 8)) % 2 == 1) && ((s / 8) <= 2 || (s / 8) >= 5);
      m_own[s]  = m_occ[s] && ((s / 8) <= 2);
      m_king[s] = 1'b0;
    end
    m_turn = START;
  endfunction

  function automatic logic [255:0] pack_board();
    logic [255:0] v;
    v = '0;
    for (int s = 0; s < 64; s++) v[4*s +: 4] = {1'b0, m_king[s], m_own[s], m_occ[s]};
    return v;
  endfunction

  function automatic bit model_legal(input int f, input int t, output bit is_jump);
    int fr, fc, tr, tc, dr, dc, ad, mid;
    fr = f / 8; fc = f % 8; tr = t / 8; tc = t % 8;
    dr = tr - fr; dc = tc - fc;
    ad = (dc < 0) ? -dc : dc;
    is_jump = 1'b0;
    if (!m_occ[f] || m_own[f] != m_turn || m_occ[t]) return 1'b0;
    if (ad != 1 && ad != 2) return 1'b0;
    if (dr != ad && dr != -ad) return 1'b0;
    if (!m_king[f] && (m_own[f] ? (dr < 0) : (dr > 0))) return 1'b0;
    if (ad == 2) begin
      mid = (fr + dr / 2) * 8 + fc + dc / 2;
      if (!m_occ[mid] || m_own[mid] == m_turn) return 1'b0;
      is_jump = 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic void model_apply();
    int mid;
    m_occ[m_t]  = 1'b1;
    m_own[m_t]  = m_own[m_f];
    m_king[m_t] = m_king[m_f] || (m_own[m_f] ? (m_t / 8 == 7) : (m_t / 8 == 0));
    m_occ[m_f] = 1'b0; m_own[m_f] = 1'b0; m_king[m_f] = 1'b0;
    if (m_jump) begin
      mid = (m_f + m_t) / 2;
      m_occ[mid] = 1'b0; m_own[mid] = 1'b0; m_king[mid] = 1'b0;
    end
    m_turn = !m_turn;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      model_init();
      m_phase = 0;
      m_started = 1'b1;
    end else begin
      case (m_phase)
        0: begin
          if (new_game) model_init();
          else if (move_valid) begin
            m_f = int'(from_sq);
            m_t = int'(to_sq);
            m_ok = model_legal(m_f, m_t, m_jump);
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        2: begin
          if (m_ok) model_apply();
          m_phase = 3;
        end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (move_done === 1'b1) saw_done = 1'b1;
    if (m_started) begin
      chkb("cyc_ready", move_ready, (m_phase == 0) && reset && !new_game);
      chkb("cyc_done", move_done, (m_phase == 3) && reset);
      if (m_phase == 3 && reset) chkb("cyc_ok", move_ok, m_ok);
      chkb("cyc_turn", turn, m_turn);
      chk("cyc_board", boardBuffer, pack_board());
    end
  end

  // Caller is in IDLE, #1 after an edge; returns #1 after the edge back into IDLE.
  task automatic do_move(input int f, input int t, input logic exp_ok, input bit ng_mid);
    move_valid = 1'b1;
    from_sq = 6'(f);
    to_sq = 6'(t);
    #1;
    chkb("mv_ready", move_ready, 1'b1);
    @(posedge clk); #1;
    from_sq = ~from_sq;
    to_sq = 6'(t + 1);
    if (ng_mid) new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    @(posedge clk); #1;
    move_valid = 1'b0;
    chkb("mv_done_n3", move_done, 1'b1);
    chkb("mv_ok", move_ok, exp_ok);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; move_valid = 1'b0; new_game = 1'b0; from_sq = '0; to_sq = '0;
    saw_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chkb("rst_ready_low", move_ready, 1'b0);
    chkb("rst_done_low", move_done, 1'b0);
    reset = 1'b1;
    #1;
    chkb("rel_ready", move_ready, 1'b1);
    chk("rel_nib1", 256'(nib(1)), 256'(4'b0011));
    chk("rel_nib0", 256'(nib(0)), 256'(4'b0000));
    chk("rel_nib40", 256'(nib(40)), 256'(4'b0001));
    chkb("rel_turn", turn, 1'b0);
    chk("rel_board", boardBuffer, INIT_LIT);

    do_move(40, 33, 1'b1, 1'b0);
    chk("m1_nib40", 256'(nib(40)), 256'(4'b0000));
    chk("m1_nib33", 256'(nib(33)), 256'(4'b0001));
    chkb("m1_turn", turn, 1'b1);

    new_game = 1'b1; move_valid = 1'b1; from_sq = 6'd19; to_sq = 6'd26;
    saw_done = 1'b0;
    #1;
    chkb("ng_ready_low", move_ready, 1'b0);
    @(posedge clk); #1;
    new_game = 1'b0; move_valid = 1'b0;
    chk("ng_board", boardBuffer, INIT_LIT);
    chkb("ng_turn", turn, 1'b0);
    repeat (4) @(posedge clk); #1;
    chkb("ng_no_move", saw_done, 1'b0);

    do_move(17, 24, 1'b0, 1'b0);
    chk("own_board", boardBuffer, INIT_LIT);
    chkb("own_turn", turn, 1'b0);
    do_move(47, 40, 1'b0, 1'b0);
    chkb("wrap_turn", turn, 1'b0);

    do_move(40, 33, 1'b1, 1'b0);
    do_move(19, 26, 1'b1, 1'b0);
    do_move(33, 19, 1'b1, 1'b0);
    chk("jmp_nib26", 256'(nib(26)), 256'(4'b0000));
    chk("jmp_nib33", 256'(nib(33)), 256'(4'b0000));
    chk("jmp_nib19", 256'(nib(19)), 256'(4'b0001));
    chkb("jmp_turn", turn, 1'b1);

    do_move(21, 30, 1'b1, 1'b0);
    do_move(44, 35, 1'b1, 1'b1);
    do_move(12, 21, 1'b1, 1'b0);
    do_move(35, 28, 1'b1, 1'b0);
    do_move(5, 12, 1'b1, 1'b0);
    do_move(19, 5, 1'b1, 1'b0);
    chk("king_nib5", 256'(nib(5)), 256'(4'b0101));
    chk("king_nib12", 256'(nib(12)), 256'(4'b0000));
    do_move(21, 12, 1'b0, 1'b1);
    do_move(21, 21, 1'b0, 1'b0);
    do_move(30, 39, 1'b1, 1'b0);
    do_move(5, 12, 1'b1, 1'b0);
    chk("kback_nib12", 256'(nib(12)), 256'(4'b0101));
    do_move(39, 40, 1'b0, 1'b0);
    chkb("wrap2_turn", turn, 1'b1);

    move_valid = 1'b1; from_sq = 6'd10; to_sq = 6'd19;
    @(posedge clk); #1;
    move_valid = 1'b0;
    reset = 1'b0;
    saw_done = 1'b0;
    #1;
    chkb("rmid_ready", move_ready, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk); #1;
    chkb("rmid_no_done", saw_done, 1'b0);
    chk("rmid_board", boardBuffer, INIT_LIT);
    chkb("rmid_turn", turn, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
